// File: rtl/adder_chain_pkg.sv
// rtl/adder_chain_pkg.sv - shared constants and segment sizing helpers for adder_chain_pipe
package adder_chain_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of pipeline segments needed to cover width bits in seg-bit pieces
  function automatic int stages(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction

  // Width of segment k; only the last one may be narrower than seg
  function automatic int seg_width(input int width, input int seg, input int k);
    int n;
    n = stages(width, seg);
    return (k == n - 1) ? (width - (n - 1) * seg) : seg;
  endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - behavioural model of the 1-bit hard adder cell
module adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sumout,
  output logic cout
);

  assign sumout = a ^ b ^ cin;
  assign cout   = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_chain_seg.sv
// rtl/adder_chain_seg.sv - combinational W-bit ripple segment built from adder cells
module adder_chain_seg #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    adder u_cell (
      .a      (a[i]),
      .b      (b[i]),
      .cin    (carry[i]),
      .sumout (sum[i]),
      .cout   (carry[i+1])
    );
  end

  assign cout = carry[W];

endmodule

// File: rtl/adder_chain_pipe.sv
// rtl/adder_chain_pipe.sv - pipelined adder/subtractor chain; ADDER_CHAIN_PIPE_SAT_EN enables saturation
module adder_chain_pipe
  import adder_chain_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int STAGES = stages(WIDTH, SEG);
  localparam int LAST   = STAGES - 1;
  // Inter-stage banks; a single-stage build keeps one idle bank so the arrays stay legal
  localparam int NB     = (STAGES > 1) ? STAGES - 1 : 1;

  logic              advance;
  logic [STAGES-1:0] vld_r;

  // Skewed operands, deskewed partial sums and boundary carries between stages
  logic [WIDTH-1:0]  a_r [NB];
  logic [WIDTH-1:0]  b_r [NB];
  logic [WIDTH-1:0]  s_r [NB];
  logic              c_r [NB];

  // Per-stage combinational view: what each stage sees and produces
  logic [WIDTH-1:0]  a_in  [STAGES];
  logic [WIDTH-1:0]  b_in  [STAGES];
  logic [WIDTH-1:0]  s_in  [STAGES];
  logic [WIDTH-1:0]  s_out [STAGES];
  logic              c_in  [STAGES];
  logic              c_out [STAGES];

  logic [WIDTH-1:0]  sum_fin;
  logic              ovf_fin;

  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance & ~flush;
  assign out_valid = vld_r[LAST];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int SW = seg_width(WIDTH, SEG, k);
    // Bits of the running sum owned by this stage; wraps to all-ones for a single full-width stage
    localparam logic [WIDTH-1:0] MASK = ((WIDTH'(1) << SW) - WIDTH'(1)) << LO;

    logic [SW-1:0] seg_sum;

    if (k == 0) begin : g_first
      assign a_in[0] = in_a;
      assign b_in[0] = (in_sub == OP_SUB) ? ~in_b : in_b;
      assign c_in[0] = (in_sub == OP_SUB) ? 1'b1 : in_cin;
      assign s_in[0] = '0;
    end else begin : g_next
      assign a_in[k] = a_r[k-1];
      assign b_in[k] = b_r[k-1];
      assign c_in[k] = c_r[k-1];
      assign s_in[k] = s_r[k-1];
    end

    adder_chain_seg #(
      .W (SW)
    ) u_seg (
      .a    (a_in[k][LO +: SW]),
      .b    (b_in[k][LO +: SW]),
      .cin  (c_in[k]),
      .sum  (seg_sum),
      .cout (c_out[k])
    );

    assign s_out[k] = (s_in[k] & ~MASK) | (WIDTH'(seg_sum) << LO);
  end

  // Overflow uses the operand MSBs that travelled with the beat to the last stage
  assign ovf_fin = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &
                   (s_out[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);

`ifdef ADDER_CHAIN_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] SMAX = ~SMIN;

  assign sum_fin = ovf_fin ? (a_in[LAST][WIDTH-1] ? SMIN : SMAX) : s_out[LAST];
`else
  assign sum_fin = s_out[LAST];
`endif

  // Whole chain moves together on advance; flush only clears the valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r    <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      for (int k = 0; k < NB; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
        c_r[k] <= 1'b0;
      end
    end else if (flush) begin
      vld_r <= '0;
    end else if (advance) begin
      vld_r[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_r[k] <= vld_r[k-1];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_r[k] <= a_in[k];
        b_r[k] <= b_in[k];
        s_r[k] <= s_out[k];
        c_r[k] <= c_out[k];
      end
      out_sum  <= sum_fin;
      out_cout <= c_out[LAST];
      out_ovf  <= ovf_fin;
    end
  end

endmodule

// File: tb/tb_adder_chain_pipe.sv
// tb/tb_adder_chain_pipe.sv - scoreboard bench for adder_chain_pipe with reference model
module tb_adder_chain_pipe;

  localparam int STG = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
    bit   lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sub = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  logic        iv7 = 1'b0, ir7, sub7 = 1'b0, cin7 = 1'b0, ov7, or7 = 1'b1, co7, of7;
  logic [6:0]  a7 = '0, b7 = '0, s7;
  logic        iv8 = 1'b0, ir8, sub8 = 1'b0, cin8 = 1'b0, ov8, or8 = 1'b1, co8, of8;
  logic [7:0]  a8 = '0, b8 = '0, s8;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  bit   lat_chk = 0;
  bit   rdy_rand = 0;
  exp_t q[$];
  res_t q7[$];
  res_t q8[$];

  adder_chain_pipe #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_sub(in_sub), .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  adder_chain_pipe #(.WIDTH(7), .SEG(3)) u7 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(iv7), .in_ready(ir7),
    .in_sub(sub7), .in_a(a7), .in_b(b7), .in_cin(cin7), .out_valid(ov7),
    .out_ready(or7), .out_sum(s7), .out_cout(co7), .out_ovf(of7)
  );

  adder_chain_pipe #(.WIDTH(8), .SEG(8)) u8 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(iv8), .in_ready(ir8),
    .in_sub(sub8), .in_a(a8), .in_b(b8), .in_cin(cin8), .out_valid(ov8),
    .out_ready(or8), .out_sum(s8), .out_cout(co8), .out_ovf(of8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Plain-arithmetic reference: w-bit add/sub with carry, signed overflow, optional clamp
  function automatic res_t ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub);
    res_t        r;
    int unsigned mask, av, bv, full;
    bit          sa, sb, ss;
    mask = (32'd1 << w) - 32'd1;
    av   = 32'(a) & mask;
    bv   = 32'(b) & mask;
    if (sub) bv = ~bv & mask;
    full = av + bv + ((sub || cin) ? 32'd1 : 32'd0);
    sa   = ((av >> (w - 1)) & 32'd1) != 0;
    sb   = ((bv >> (w - 1)) & 32'd1) != 0;
    ss   = ((full >> (w - 1)) & 32'd1) != 0;
    r.sum  = 16'(full & mask);
    r.cout = ((full >> w) & 32'd1) != 0;
    r.ovf  = (sa == sb) && (ss != sa);
`ifdef ADDER_CHAIN_PIPE_SAT_EN
    if (r.ovf) r.sum = sa ? 16'(32'd1 << (w - 1)) : 16'(mask >> 1);
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Main scoreboard: retire on output handshake, enqueue on input handshake, drop on flush
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        chk("beat_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sum", 32'(out_sum), 32'(e.r.sum));
          chk("cout", 32'(out_cout), 32'(e.r.cout));
          chk("ovf", 32'(out_ovf), 32'(e.r.ovf));
          if (e.lat) chk("latency", 32'(cyc - e.acc), 32'(STG));
        end
      end
      chk("in_ready", 32'(in_ready), 32'((!out_valid || out_ready) && !flush));
      if (flush) q.delete();
      else if (in_valid && in_ready) begin
        e.r   = ref_op(16, in_a, in_b, in_cin, in_sub);
        e.acc = cyc;
        e.lat = lat_chk;
        q.push_back(e);
      end
    end
  end

  // Scoreboards for the ragged and single-stage builds
  always @(negedge clk) begin
    res_t g, e;
    if (rst_n) begin
      if (ov7 && or7) begin
        chk("w7_beat_expected", 32'(q7.size() != 0), 32'd1);
        if (q7.size() != 0) begin
          e = q7.pop_front();
          g.sum = 16'(s7); g.cout = co7; g.ovf = of7;
          chk("w7_result", 32'(g), 32'(e));
        end
      end
      if (iv7 && ir7) q7.push_back(ref_op(7, 16'(a7), 16'(b7), cin7, sub7));
      if (ov8 && or8) begin
        chk("w8_beat_expected", 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          g.sum = 16'(s8); g.cout = co8; g.ovf = of8;
          chk("w8_result", 32'(g), 32'(e));
        end
      end
      if (iv8 && ir8) q8.push_back(ref_op(8, 16'(a8), 16'(b8), cin8, sub8));
    end
  end

  always @(posedge clk) begin
    #2;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    bit acc = 0;
    int t = 0;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
      t++;
    end
    chk("accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] iv;
    int          t;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_cout", 32'(out_cout), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk);
    #2;

    // Directed beats with latency checking
    lat_chk = 1; out_ready = 1'b1;
    send(16'h1234, 16'h1111, 1'b1, 1'b0);
    drain();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0000, 16'h0001, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drain();

    // Random stream under random backpressure
    lat_chk = 0; rdy_rand = 1;
    for (int i = 0; i < 20; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    rdy_rand = 0; out_ready = 1'b1;
    drain();

    // Flush with three beats in flight and a beat offered during flush
    lat_chk = 1;
    for (int i = 0; i < 3; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    flush = 1'b1; in_valid = 1'b1; in_a = 16'h0F0F; in_b = 16'h0101;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #2;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    repeat (6) @(negedge clk);
    chk("flush_quiet", 32'(out_valid), 32'd0);
    @(posedge clk);
    #2;
    send(16'h4321, 16'h1234, 1'b0, 1'b0);
    drain();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_out_sum", 32'(out_sum), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_after", 32'(out_valid), 32'd0);
    @(posedge clk);
    #2;
    send(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
    drain();

    // Ragged 7/3 build exhaustively; single-stage 8/8 build with random operands
    iv7 = 1'b1; iv8 = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      iv = 16'(i);
      a7 = iv[6:0]; b7 = iv[13:7]; cin7 = iv[14]; sub7 = iv[15];
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
      @(posedge clk);
      #2;
    end
    iv7 = 1'b0; iv8 = 1'b0;
    t = 0;
    while ((q7.size() != 0 || q8.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("w7_drain", 32'(q7.size()), 32'd0);
    chk("w8_drain", 32'(q8.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
